window_average_collector: RTL and testbench

- Downstream stage of the scale/accumulate datapath. Consumes its 32-bit result word and valid strobe.
- Groups consecutive valid words into fixed windows of 2^LOG2_WIN samples.
- For each window, produces the truncated average, the maximum, and a threshold flag.
- Results leave through a valid/ready output channel. Overruns are counted, because the upstream stage cannot be back-pressured.

---
 rtl/window_average_collector.sv | 164 ++++++++++++++++
 tb/tb_window_average_collector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/window_average_collector.sv
`default_nettype none
// ============================================================================
//  Module   : window_average_collector
//  Purpose  : Groups consecutive valid samples into windows of 2^LOG2_WIN,
//             emits the truncated average, the maximum and a threshold flag
//             through a one-entry valid/ready register, and counts results
//             dropped because the downstream side was stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module window_average_collector #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      LOG2_WIN  = 3,
   parameter logic [WIDTH-1:0] THRESHOLD = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   input  logic             flush,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] avg_out,
   output logic [WIDTH-1:0] max_out,
   output logic             above_thr,
   output logic             overrun,
   output logic [7:0]       ovr_count
);

   localparam int unsigned         ACC_W    = WIDTH + LOG2_WIN;
   // Index of the final sample of a window (2^LOG2_WIN - 1).
   localparam logic [LOG2_WIN-1:0] LAST_CNT = '1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ACCUM = 1'b1;

   // Collection state
   logic [0:0]          state_q,   state_d;
   logic [LOG2_WIN-1:0] count_q,   count_d;
   logic [ACC_W-1:0]    acc_q,     acc_d;
   logic [WIDTH-1:0]    max_q,     max_d;

   // Output register and overrun bookkeeping
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    avg_q,       avg_d;
   logic [WIDTH-1:0]    omax_q,      omax_d;
   logic                thr_q,       thr_d;
   logic                overrun_q,   overrun_d;
   logic [7:0]          ovr_cnt_q,   ovr_cnt_d;

   // Window contents the incoming sample builds on: empty when idle or when
   // a flush discards the partial window in this same cycle.
   logic                base_empty_w;
   logic [LOG2_WIN-1:0] base_cnt_w;
   logic [ACC_W-1:0]    base_acc_w;
   logic [WIDTH-1:0]    base_max_w;
   logic [ACC_W-1:0]    sum_w;
   logic [WIDTH-1:0]    max_new_w;
   logic [WIDTH-1:0]    avg_new_w;
   logic                complete_w;
   logic                load_w;
   logic                drop_w;

   assign base_empty_w = flush || (state_q == S_IDLE);
   assign base_cnt_w   = base_empty_w ? '0 : count_q;
   assign base_acc_w   = base_empty_w ? '0 : acc_q;
   assign base_max_w   = base_empty_w ? '0 : max_q;

   assign sum_w        = base_acc_w + ACC_W'(data_in);
   assign max_new_w    = (data_in > base_max_w) ? data_in : base_max_w;
   assign avg_new_w    = sum_w[ACC_W-1:LOG2_WIN];
   assign complete_w   = valid_in && (base_cnt_w == LAST_CNT);

   // A completed window is loaded when the register is empty or being
   // drained on this edge; otherwise it is lost and counted.
   assign load_w       = complete_w && (!out_valid_q || out_ready);
   assign drop_w       = complete_w &&   out_valid_q && !out_ready;

   // Next state of the sample collector (flush first, then capture).
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      max_d   = max_q;
      if (flush) begin
         state_d = S_IDLE;
         count_d = '0;
         acc_d   = '0;
         max_d   = '0;
      end
      if (valid_in) begin
         if (complete_w) begin
            state_d = S_IDLE;
            count_d = '0;
            acc_d   = '0;
            max_d   = '0;
         end else begin
            state_d = S_ACCUM;
            count_d = base_cnt_w + LOG2_WIN'(1);
            acc_d   = sum_w;
            max_d   = max_new_w;
         end
      end
   end

   // Next state of the output register and the overrun counters.
   always_comb begin
      out_valid_d = out_valid_q;
      avg_d       = avg_q;
      omax_d      = omax_q;
      thr_d       = thr_q;
      overrun_d   = overrun_q;
      ovr_cnt_d   = ovr_cnt_q;
      if (load_w) begin
         out_valid_d = 1'b1;
         avg_d       = avg_new_w;
         omax_d      = max_new_w;
         thr_d       = (avg_new_w > THRESHOLD);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (drop_w) begin
         overrun_d = 1'b1;
         if (ovr_cnt_q != 8'hFF) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
         end
      end
   end

   // State registers; reset takes priority over every other event.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         acc_q       <= '0;
         max_q       <= '0;
         out_valid_q <= 1'b0;
         avg_q       <= '0;
         omax_q      <= '0;
         thr_q       <= 1'b0;
         overrun_q   <= 1'b0;
         ovr_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         max_q       <= max_d;
         out_valid_q <= out_valid_d;
         avg_q       <= avg_d;
         omax_q      <= omax_d;
         thr_q       <= thr_d;
         overrun_q   <= overrun_d;
         ovr_cnt_q   <= ovr_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign avg_out   = avg_q;
   assign max_out   = omax_q;
   assign above_thr = thr_q;
   assign overrun   = overrun_q;
   assign ovr_count = ovr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_window_average_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_average_collector
//  Purpose  : Scoreboard bench for window_average_collector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window_average_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data_in;
   logic        valid_in;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] avg_out;
   logic [31:0] max_out;
   logic        above_thr;
   logic        overrun;
   logic [7:0]  ovr_count;

   always #5 clk = ~clk;

   window_average_collector dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .flush     (flush),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .avg_out   (avg_out),
      .max_out   (max_out),
      .above_thr (above_thr),
      .overrun   (overrun),
      .ovr_count (ovr_count)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] avg;
      logic [31:0] mx;
      logic        thr;
   } res_t;

   res_t sb[$];

   // Reference model of the window collector and output occupancy.
   int          m_cnt;
   logic [34:0] m_sum;
   logic [31:0] m_max;
   bit          m_full;
   bit          m_overrun;
   int          m_ovr;

   task automatic model_clear();
      m_cnt = 0; m_sum = '0; m_max = '0;
      m_full = 0; m_overrun = 0; m_ovr = 0;
      sb.delete();
   endtask

   // One clock: drive inputs, predict the coming edge, then check after it.
   task automatic step(input logic [31:0] d, input logic v, input logic f);
      bit   done;
      res_t r;
      done     = 0;
      data_in  = d;
      valid_in = v;
      flush    = f;
      if (f) begin
         m_cnt = 0; m_sum = '0; m_max = '0;
      end
      if (v) begin
         m_sum = m_sum + {3'b000, d};
         if (d > m_max) m_max = d;
         m_cnt++;
         if (m_cnt == 8) begin
            done  = 1;
            r.avg = m_sum[34:3];
            r.mx  = m_max;
            r.thr = (r.avg > 32'd2);
            m_cnt = 0; m_sum = '0; m_max = '0;
         end
      end
      if (done && m_full && !out_ready) begin
         m_overrun = 1;
         if (m_ovr < 255) m_ovr++;
      end else if (done) begin
         sb.push_back(r);
         m_full = 1;
      end else if (m_full && out_ready) begin
         m_full = 0;
      end
      @(posedge clk); #1;
      check("out_valid", {63'd0, out_valid}, {63'd0, m_full});
      check("overrun",   {63'd0, overrun},   {63'd0, m_overrun});
      check("ovr_count", {56'd0, ovr_count}, 64'(m_ovr));
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      valid_in = 1'b1;
      data_in  = 32'd9;
      flush    = 1'b0;
      @(posedge clk); #1;
      rst_n    = 1'b1;
      valid_in = 1'b0;
      model_clear();
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_avg",   {32'd0, avg_out},   64'd0);
      check("rst_max",   {32'd0, max_out},   64'd0);
      check("rst_thr",   {63'd0, above_thr}, 64'd0);
      check("rst_ovr",   {63'd0, overrun},   64'd0);
      check("rst_ocnt",  {56'd0, ovr_count}, 64'd0);
   endtask

   // Output-side scoreboard: compare each result as it is transferred.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_result", {32'd0, avg_out}, 64'hDEAD);
         end else begin
            res_t e;
            e = sb.pop_front();
            check("avg_out",   {32'd0, avg_out},   {32'd0, e.avg});
            check("max_out",   {32'd0, max_out},   {32'd0, e.mx});
            check("above_thr", {63'd0, above_thr}, {63'd0, e.thr});
         end
      end
   end

   initial begin
      rst_n = 1'b0; data_in = '0; valid_in = 1'b0; flush = 1'b0; out_ready = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Ramp 1..8, downstream always ready.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) step(32'(i), 1'b1, 1'b0);
      step(32'd0, 1'b0, 1'b0);

      // Zeros then 16 with idle gaps; strict threshold compare.
      for (int i = 0; i < 8; i++) begin
         step((i == 7) ? 32'd16 : 32'd0, 1'b1, 1'b0);
         step($urandom, 1'b0, 1'b0);
      end

      // Full-scale samples: no accumulator wrap.
      for (int i = 0; i < 8; i++) step(32'hFFFF_FFFF, 1'b1, 1'b0);
      step(32'd0, 1'b0, 1'b0);

      // Stalled downstream: first result held, second dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) step(32'd5, 1'b1, 1'b0);
      step(32'd0, 1'b0, 1'b0);
      check("held_avg", {32'd0, avg_out}, 64'd5);
      check("held_max", {32'd0, max_out}, 64'd5);
      out_ready = 1'b1;
      step(32'd0, 1'b0, 1'b0);
      step(32'd0, 1'b0, 1'b0);

      // Flush discards the partial window of 100s.
      for (int i = 0; i < 3; i++) step(32'd100, 1'b1, 1'b0);
      step(32'd3, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(32'd3, 1'b1, 1'b0);
      step(32'd0, 1'b0, 1'b0);

      // Reset with a pending result and a partial window in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) step(32'd1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(32'd9, 1'b1, 1'b0);
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) step(32'd7, 1'b1, 1'b0);
      step(32'd0, 1'b0, 1'b0);
      step(32'd0, 1'b0, 1'b0);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
